mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit for the 54-instruction pipelined CPU.
- Executes MULT, MULTU, DIV and DIVU on the rs/rt operand values.
- Drives the MDU_r1 (HI-side) and MDU_r2 (LO-side) results that feed the HI/LO write-back selectors and the register-file data selector.
- The pipeline stall logic uses busy/done to hold dependent instructions (MFHI/MFLO, MUL) until results are valid.

---
 rtl/mdu_iterative_if.sv | 26 ++
 rtl/mdu_iterative.sv | 156 +++++++++++++++
 tb/tb_mdu_iterative.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Handshake and result bundle between the pipeline and the multiply/divide unit.
// The master side launches or flushes operations; the slave side returns status and results.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;

  modport master (
    output start, cancel, op, a, b,
    input  busy, done, dbz, r1, r2
  );

  modport slave (
    input  start, cancel, op, a, b,
    output busy, done, dbz, r1, r2
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to route multiplies through a single-cycle multiplier.
module mdu_iterative #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] DBZ_QUOT = '1
) (
  input logic            clk,
  input logic            rst_n,
  mdu_iterative_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_a;
  logic             r_div;
  logic             r_negq;
  logic             r_negr;
  logic             r_dz;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_pfix;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic             w_fast;

  assign w_sa = ~bus.op[0] & bus.a[WIDTH-1];
  assign w_sb = ~bus.op[0] & bus.b[WIDTH-1];
  assign w_ma = w_sa ? -bus.a : bus.a;
  assign w_mb = w_sb ? -bus.b : bus.b;

  // Multiply step: r_hi:r_lo is the accumulator, r_d the multiplicand
  assign w_sum  = {1'b0, r_hi} + {1'b0, r_d};
  assign w_madd = r_lo[0] ? w_sum : {1'b0, r_hi};

  // Divide step: r_hi is the partial remainder, r_lo dividend/quotient
  assign w_t    = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = w_t >= {1'b0, r_d};
  assign w_diff = w_t[WIDTH-1:0] - r_d;

`ifdef MDU_FAST_MUL_EN
  assign w_prod = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_lo};
  assign w_fast = ~bus.op[1];
`else
  assign w_prod = {r_hi, r_lo};
  assign w_fast = 1'b0;
`endif

  assign w_pfix = r_negq ? -w_prod : w_prod;
  assign w_q    = r_negq ? -r_lo : r_lo;
  assign w_r    = r_negr ? -r_hi : r_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
      r_a     <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_r1    <= '0;
      r_r2    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (bus.start && !bus.cancel) begin
            r_a    <= bus.a;
            r_div  <= bus.op[1];
            r_cnt  <= '0;
            r_hi   <= '0;
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_state <= w_fast ? S_FIX : S_CALC;
            if (bus.op[1]) begin
              r_d  <= w_mb;
              r_lo <= w_ma;
              r_dz <= (bus.b == '0);
            end else begin
              r_d  <= w_ma;
              r_lo <= w_mb;
              r_dz <= 1'b0;
            end
          end
        end
        (r_state == S_CALC): begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (r_div) begin
              r_hi <= w_ge ? w_diff : w_t[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) r_state <= S_FIX;
          end
        end
        (r_state == S_FIX): begin
          r_state <= S_IDLE;
          if (!bus.cancel) begin
            r_done <= 1'b1;
            r_dbz  <= r_dz;
            if (!r_div) begin
              {r_r1, r_r2} <= w_pfix;
            end else if (r_dz) begin
              r_r1 <= r_a;
              r_r2 <= DBZ_QUOT;
            end else begin
              r_r1 <= w_r;
              r_r2 <= w_q;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.dbz  = r_dbz;
  assign bus.r1   = r_r1;
  assign bus.r2   = r_r2;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed vectors, latency/busy checks,
// cancel, held start, back-to-back start and mid-operation reset.
module tb_mdu_iterative;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        dz;
    int          e0;
    int          lat;
    string       nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edges;
  int   run;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];
  exp_t e;

  mdu_iterative_if #(.WIDTH(32)) bus ();

  mdu_iterative #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got r1=%h r2=%h expected no done",
                 bus.r1, bus.r2);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_r1"}, bus.r1, e.r1);
        chk({e.nm, "_r2"}, bus.r2, e.r2);
        chk({e.nm, "_dbz"}, {31'b0, bus.dbz}, {31'b0, e.dz});
        chk({e.nm, "_lat"}, 32'(edges - e.e0), 32'(e.lat));
        chk({e.nm, "_busy"}, 32'(run), 32'(e.lat));
      end
    end
    if (bus.busy === 1'b1) run++;
    else run = 0;
  end

  task automatic push(input logic [1:0] op, input logic [31:0] r1,
                      input logic [31:0] r2, input logic dz,
                      input string nm);
    exp_t x;
    x.r1  = r1;
    x.r2  = r2;
    x.dz  = dz;
    x.e0  = edges;
    x.lat = (FAST && !op[1]) ? 1 : 33;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r1,
                       input logic [31:0] r2, input logic dz,
                       input string nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    push(op, r1, r2, dz, nm);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic quiet(input string nm);
    chk({nm, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_fail = 0;
    run = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    quiet("rst");
    chk("rst_dbz", {31'b0, bus.dbz}, 32'd0);
    chk("rst_r1", bus.r1, 32'd0);
    chk("rst_r2", bus.r2, 32'd0);
    rst_n = 1'b1;

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    wait_idle("multu_max");
    issue(MULT, 32'hFFFFFFFD, 32'h00000007,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg");
    wait_idle("mult_neg");
    issue(MULT, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h00000000, 1'b0, "mult_min");
    wait_idle("mult_min");
    issue(DIV, 32'hFFFFFFF9, 32'h00000002,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
    wait_idle("div_neg");
    issue(DIV, 32'h00000007, 32'hFFFFFFFE,
          32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negb");
    wait_idle("div_negb");
    issue(DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000, 1'b0, "div_ovf");
    wait_idle("div_ovf");
    issue(DIVU, 32'h12345678, 32'h00000000,
          32'h12345678, 32'hFFFFFFFF, 1'b1, "divu_dbz");
    wait_idle("divu_dbz");
    issue(DIV, 32'hFFFFFFF9, 32'h00000000,
          32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_dbz");
    wait_idle("div_dbz");
    issue(MULTU, 32'h12345678, 32'h00000009,
          32'h00000000, 32'hA3D70A38, 1'b0, "multu_small");
    wait_idle("multu_small");

    @(negedge clk);
    bus.start = 1'b1;
    bus.op = DIVU;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    quiet("cancel");
    chk("cancel_r1", bus.r1, 32'h00000000);
    chk("cancel_r2", bus.r2, 32'hA3D70A38);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_after_cancel");
    wait_idle("divu_after_cancel");

    @(negedge clk);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.op = MULTU;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    @(negedge clk);
    quiet("cancel_start");
    repeat (40) @(negedge clk);
    chk("cancel_start_r2", bus.r2, 32'd14);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op = DIVU;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    push(DIVU, 32'd1, 32'd333, 1'b0, "held_a");
    repeat (5) @(negedge clk);
    bus.a = 32'h0000DEAD;
    bus.b = 32'h00000000;
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL held_a_timeout: got no done expected done");
    end
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'h00000010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    push(DIVU, 32'h0000000F, 32'h0FFFFFFF, 1'b0, "b2b_b");
    wait_idle("b2b_b");

    @(negedge clk);
    bus.start = 1'b1;
    bus.op = DIV;
    bus.a = 32'd50;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    quiet("midrst");
    chk("midrst_r1", bus.r1, 32'd0);
    chk("midrst_r2", bus.r2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    quiet("midrst_after");
    issue(MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "mult_after_rst");
    wait_idle("mult_after_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

endmodule
